// File: rtl/cond_flag_unit_pkg.sv
// Shared ALU definitions: status-word layout and condition-code encodings.
// Imported by the flag unit and its condition decoder.
package cond_flag_unit_pkg;

    localparam int unsigned WIDTH       = 4;
    localparam int unsigned ST_NEG      = 3;
    localparam int unsigned ST_ZERO     = 2;
    localparam int unsigned ST_CARRY    = 1;
    localparam int unsigned ST_OVERFLOW = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_code_e;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational condition decoder: evaluates a 4-bit condition code against NZCV flags.
module cond_eval
    import cond_flag_unit_pkg::*;
(
    input  logic [WIDTH-1:0] flags,
    input  logic [3:0]       condCode,
    output logic             result
);

    logic n, z, c, v;

    always_comb begin
        n      = flags[ST_NEG];
        z      = flags[ST_ZERO];
        c      = flags[ST_CARRY];
        v      = flags[ST_OVERFLOW];
        result = 1'b0;
        unique case (cond_code_e'(condCode))
            COND_EQ: result = z;
            COND_NE: result = !z;
            COND_CS: result = c;
            COND_CC: result = !c;
            COND_MI: result = n;
            COND_PL: result = !n;
            COND_VS: result = v;
            COND_VC: result = !v;
            COND_HI: result = c && !z;
            COND_LS: result = !c || z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = !z && (n == v);
            COND_LE: result = z || (n != v);
            COND_AL: result = 1'b1;
            COND_NV: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Condition flag register with a save/restore stack and a one-cycle registered
// condition evaluator.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             statusIn,
    input  logic                         flagWrite,
    input  logic [WIDTH-1:0]             flagMask,
    input  logic                         push,
    input  logic                         pop,
    input  logic [3:0]                   condCode,
    input  logic                         condValid,
    output logic [WIDTH-1:0]             flagsOut,
    output logic                         condTrue,
    output logic                         condTrueValid,
    output logic [$clog2(STACK_DEPTH):0] stackDepth,
    output logic                         stackFull,
    output logic                         stackEmpty,
    output logic                         stackErr
);

    localparam int unsigned AW = $clog2(STACK_DEPTH);
    localparam int unsigned DW = AW + 1;

    logic [WIDTH-1:0] flags_q, flags_d;
    logic [DW-1:0]    depth_q, depth_d, depth_m1;
    logic             err_q, err_d;
    logic             cond_q, cond_valid_q;
    logic             cond_res;
    logic             full, empty, push_ok, pop_ok, stack_fault;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    cond_eval u_cond_eval (
        .flags    (flags_q),
        .condCode (condCode),
        .result   (cond_res)
    );

    always_comb begin
        full        = (depth_q == DW'(STACK_DEPTH));
        empty       = (depth_q == '0);
        depth_m1    = depth_q - {{(DW-1){1'b0}}, 1'b1};
        wr_idx      = depth_q[AW-1:0];
        rd_idx      = depth_m1[AW-1:0];
        push_ok     = push && !pop && !full;
        pop_ok      = pop && !push && !empty;
        // Push+pop together, push on full and pop on empty are all stack faults.
        stack_fault = (push && pop) || (push && full) || (pop && empty);

        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q || stack_fault;
        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
            depth_d = depth_m1;
        end else if (flagWrite) begin
            flags_d = (flags_q & ~flagMask) | (statusIn & flagMask);
        end
        if (push_ok) begin
            depth_d = depth_q + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= '0;
            depth_q      <= '0;
            err_q        <= 1'b0;
            cond_q       <= 1'b0;
            cond_valid_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            depth_q      <= depth_d;
            err_q        <= err_d;
            cond_valid_q <= condValid;
            if (condValid) begin
                cond_q <= cond_res;
            end
        end
    end

    // Storage is deliberately unreset; an empty stack can never be read.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

    always_comb begin
        flagsOut      = flags_q;
        condTrue      = cond_q;
        condTrueValid = cond_valid_q;
        stackDepth    = depth_q;
        stackFull     = full;
        stackEmpty    = empty;
        stackErr      = err_q;
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed self-checking bench for cond_flag_unit; condition results are
// scoreboarded through a queue of expected values.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] statusIn;
    logic       flagWrite;
    logic [3:0] flagMask;
    logic       push;
    logic       pop;
    logic [3:0] condCode;
    logic       condValid;
    logic [3:0] flagsOut;
    logic       condTrue;
    logic       condTrueValid;
    logic [2:0] stackDepth;
    logic       stackFull;
    logic       stackEmpty;
    logic       stackErr;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    cond_flag_unit #(.STACK_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .statusIn      (statusIn),
        .flagWrite     (flagWrite),
        .flagMask      (flagMask),
        .push          (push),
        .pop           (pop),
        .condCode      (condCode),
        .condValid     (condValid),
        .flagsOut      (flagsOut),
        .condTrue      (condTrue),
        .condTrueValid (condTrueValid),
        .stackDepth    (stackDepth),
        .stackFull     (stackFull),
        .stackEmpty    (stackEmpty),
        .stackErr      (stackErr)
    );

    always #5 clk = ~clk;

    // Reference: even codes give a base predicate, odd codes its complement.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return code[0] ? ~base : base;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flagWrite = 1'b0; push = 1'b0; pop = 1'b0; condValid = 1'b0; rst = 1'b0;
        statusIn = 4'h0; flagMask = 4'h0; condCode = 4'h0;
    endtask

    // Advance one clock and retire any condition result through the scoreboard.
    task automatic tick();
        logic e;
        @(posedge clk);
        #1;
        if (condTrueValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_condTrueValid", 32'(condTrueValid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("condTrue", 32'(condTrue), 32'(e));
            end
        end else if (exp_q.size() != 0) begin
            check("missing_condTrueValid", 32'(condTrueValid), 32'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic write_flags(input logic [3:0] v);
        flagWrite = 1'b1; flagMask = 4'hF; statusIn = v;
        tick();
        idle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_flags"}, 32'(flagsOut), 32'h0);
        check({tag, "_depth"}, 32'(stackDepth), 32'd0);
        check({tag, "_empty"}, 32'(stackEmpty), 32'd1);
        check({tag, "_full"}, 32'(stackFull), 32'd0);
        check({tag, "_err"}, 32'(stackErr), 32'd0);
        check({tag, "_ctv"}, 32'(condTrueValid), 32'd0);
        check({tag, "_ct"}, 32'(condTrue), 32'd0);
    endtask

    initial begin
        logic [3:0] vals [4];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Masked write.
        flagWrite = 1'b1; statusIn = 4'hF; flagMask = 4'b0101;
        tick();
        idle();
        check("masked_write", 32'(flagsOut), 32'h5);

        // All 16 codes against NZCV=1001, back to back.
        write_flags(4'b1001);
        check("flags_1001", 32'(flagsOut), 32'h9);
        check("ref_EQ", 32'(ref_cond(4'b1001, 4'h0)), 32'd0);
        check("ref_GE", 32'(ref_cond(4'b1001, 4'hA)), 32'd1);
        check("ref_GT", 32'(ref_cond(4'b1001, 4'hC)), 32'd1);
        check("ref_LT", 32'(ref_cond(4'b1001, 4'hB)), 32'd0);
        check("ref_HI", 32'(ref_cond(4'b1001, 4'h8)), 32'd0);
        for (int i = 0; i < 16; i++) begin
            condValid = 1'b1;
            condCode  = 4'(i);
            exp_q.push_back(ref_cond(4'b1001, 4'(i)));
            tick();
        end
        idle();
        tick();
        check("ctv_low_after", 32'(condTrueValid), 32'd0);
        check("ct_held_NV", 32'(condTrue), 32'd0);

        // Stack round trip.
        for (int i = 0; i < 4; i++) begin
            write_flags(vals[i]);
            push = 1'b1;
            tick();
            idle();
        end
        check("full_after4", 32'(stackFull), 32'd1);
        check("depth_after4", 32'(stackDepth), 32'd4);
        check("err_before5", 32'(stackErr), 32'd0);
        push = 1'b1;
        tick();
        idle();
        check("err_push_full", 32'(stackErr), 32'd1);
        check("depth_push_full", 32'(stackDepth), 32'd4);
        write_flags(4'h0);
        for (int i = 3; i >= 0; i--) begin
            pop = 1'b1;
            tick();
            idle();
            check($sformatf("pop_%0d", i), 32'(flagsOut), 32'(vals[i]));
        end
        check("empty_after_pops", 32'(stackEmpty), 32'd1);

        // Simultaneous events.
        rst = 1'b1;
        tick();
        idle();
        write_flags(4'b0011);
        push = 1'b1; flagWrite = 1'b1; flagMask = 4'hF; statusIn = 4'b1100;
        tick();
        idle();
        check("pushwr_flags", 32'(flagsOut), 32'hC);
        check("pushwr_depth", 32'(stackDepth), 32'd1);
        pop = 1'b1; flagWrite = 1'b1; flagMask = 4'hF; statusIn = 4'b0101;
        tick();
        idle();
        check("popwr_flags", 32'(flagsOut), 32'h3);
        check("popwr_depth", 32'(stackDepth), 32'd0);
        check("popwr_err", 32'(stackErr), 32'd0);
        push = 1'b1; pop = 1'b1; flagWrite = 1'b1; flagMask = 4'hF; statusIn = 4'b0110;
        tick();
        idle();
        check("pushpop_depth", 32'(stackDepth), 32'd0);
        check("pushpop_err", 32'(stackErr), 32'd1);
        check("pushpop_flags", 32'(flagsOut), 32'h6);

        // No forwarding of a same-cycle write into the evaluation.
        rst = 1'b1;
        tick();
        idle();
        flagWrite = 1'b1; flagMask = 4'hF; statusIn = 4'b0100;
        condValid = 1'b1; condCode = 4'h0;
        exp_q.push_back(1'b0);
        tick();
        idle();
        check("nofwd_flags", 32'(flagsOut), 32'h4);
        condValid = 1'b1; condCode = 4'h0;
        exp_q.push_back(1'b1);
        tick();
        idle();

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) begin
            write_flags(vals[i]);
            push = 1'b1;
            tick();
            idle();
        end
        push = 1'b1; pop = 1'b1;
        condValid = 1'b1; condCode = 4'hE;
        exp_q.push_back(1'b1);
        tick();
        idle();
        check("mid_depth3", 32'(stackDepth), 32'd3);
        check("mid_err", 32'(stackErr), 32'd1);
        rst = 1'b1; push = 1'b1; flagWrite = 1'b1; flagMask = 4'hF; statusIn = 4'hF;
        tick();
        idle();
        check_reset_state("midrst");
        pop = 1'b1;
        tick();
        idle();
        check("post_pop_err", 32'(stackErr), 32'd1);
        check("post_pop_flags", 32'(flagsOut), 32'h0);
        check("post_pop_depth", 32'(stackDepth), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, giving the number of saved flag sets (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port statusIn, input, 4, ALU status word indexed by ST_NEG/ST_ZERO/ST_CARRY/ST_OVERFLOW.
REQ-005 SHALL have port flagWrite, input, 1, strobe to load statusIn into the flag register.
REQ-006 SHALL have port flagMask, input, 4, per-bit write enable qualifying flagWrite.
REQ-007 SHALL have port push, input, 1, save current flags onto the stack.
REQ-008 SHALL have port pop, input, 1, restore flags from the stack top.
REQ-009 SHALL have port condCode, input, 4, condition selector.
REQ-010 SHALL have port condValid, input, 1, condition evaluation request.
REQ-011 SHALL have port flagsOut, output, 4, current flag register.
REQ-012 SHALL have port condTrue, output, 1, registered evaluation result.
REQ-013 SHALL have port condTrueValid, output, 1, qualifies condTrue.
REQ-014 SHALL have port stackDepth, output, clog2(STACK_DEPTH)+1, number of saved entries.
REQ-015 SHALL have ports stackFull, stackEmpty, stackErr, output, 1 each; stackErr sticky.

Function
REQ-016 SHALL update on flagWrite: flags <= (flags & ~flagMask) | (statusIn & flagMask); visible on flagsOut next cycle.
REQ-017 SHALL on push (not full, no pop) write the pre-edge flags into stack[stackDepth] and increment stackDepth.
REQ-018 SHALL on pop (not empty, no push) load flags from stack[stackDepth-1] and decrement stackDepth; pop overrides flagWrite in the same cycle.
REQ-019 SHALL on push with flagWrite in the same cycle save the old flags and apply the write to the flag register.
REQ-020 SHALL treat push and pop asserted together as a stack no-op, set stackErr, and still apply flagWrite.
REQ-021 SHALL ignore push when full and pop when empty (flags and depth unchanged) and set stackErr.
REQ-022 SHALL assert stackFull when stackDepth==STACK_DEPTH, stackEmpty when stackDepth==0, combinationally from depth.
REQ-023 SHALL evaluate condCode against the pre-edge flags register (no forwarding of same-cycle writes/pops).
REQ-024 SHALL decode condCode: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-025 SHALL register condTrue and condTrueValid with exactly 1-cycle latency from condValid; condTrueValid low and condTrue held otherwise.
REQ-026 SHALL accept a new condValid every cycle (fully pipelined, no back-pressure).

Reset
REQ-027 SHALL on rst clear flags, stackDepth, stackErr, condTrue, condTrueValid to 0 (stackEmpty=1, stackFull=0), with rst overriding all other inputs that cycle.
REQ-028 SHALL leave stack storage unreset; contents are unobservable because pop on empty is ignored.

Structure
REQ-029 SHALL take WIDTH, ST_NEG=3, ST_ZERO=2, ST_CARRY=1, ST_OVERFLOW=0 and COND_EQ..COND_NV codes from the shared ALU package.
REQ-030 SHALL place the condition decode in one combinational sub-module cond_eval (flags, condCode -> result).

Verification
REQ-031 SHALL cover masked write: flags=0000, flagWrite, statusIn=1111, mask=0101 -> flagsOut=0101 next cycle.
REQ-032 SHALL cover all 16 codes for flags NZCV=1001 (N=1,V=1): EQ=0, GE=1, GT=1, LT=0, HI=0, AL=1, NV=0, each 1 cycle after condValid.
REQ-033 SHALL cover stack round trip: push 0001,0010,0100,1000 -> stackFull=1; 5th push -> stackErr=1, depth 4; four pops restore 1000,0100,0010,0001, then stackEmpty=1.
REQ-034 SHALL cover simultaneous events: push+flagWrite saves old value; pop+flagWrite yields popped value; push+pop leaves depth unchanged and sets stackErr.
REQ-035 SHALL cover no-forwarding: flagWrite Z=1 and condValid EQ in same cycle with Z=0 -> condTrue=0.
REQ-036 SHALL cover reset mid-operation: depth 3, stackErr=1, rst one cycle -> all outputs at reset values; subsequent pop -> stackErr=1, flags=0000.
